// File: rtl/memory_data_distributor_pkg.sv
// Shared definitions for memory_data_distributor: FSM state encodings,
// destination selects and the word substituted when the read watchdog fires.
package memory_data_distributor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_DELIVER = 2'd2
    } state_t;

    localparam logic        DEST_ZERO    = 1'b0;
    localparam logic        DEST_ONE     = 1'b1;
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    // A consumer channel is offered data only while delivering to that channel.
    function automatic logic channel_valid(input state_t state, input logic dest, input logic channel);
        return (state == ST_DELIVER) && (dest == channel);
    endfunction

endpackage

// File: rtl/memory_data_distributor_mem_wait_counter.sv
// Clearable saturating cycle counter; terminal is high once LIMIT enabled
// cycles have elapsed since the last clear (count reached LIMIT-1).
module mem_wait_counter #(
    parameter int unsigned LIMIT = 15
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/memory_data_distributor.sv
// Issues one memory read per request and hands the returned word to consumer Zero or One.
// Define MEM_READ_TIMEOUT_EN to enable the READ-state watchdog (sticky timeout_err).
module memory_data_distributor
    import memory_data_distributor_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_dest,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              zero_valid,
    output logic [DATA_W-1:0] zero_data,
    input  logic              zero_ack,
    output logic              one_valid,
    output logic [DATA_W-1:0] one_data,
    input  logic              one_ack,
    output logic              busy,
    output logic              timeout_err
);

    state_t            state, state_next;
    logic              dest_q, dest_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [DATA_W-1:0] data_q, data_next;
    logic              dest_ack;
    logic              expire;

`ifdef MEM_READ_TIMEOUT_EN
    logic timeout_q;
    logic wait_done;

    mem_wait_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_counter (
        .CLK     (CLK),
        .Reset   (Reset),
        .clear   (state != ST_READ),
        .enable  (state == ST_READ),
        .terminal(wait_done)
    );

    assign expire = wait_done;

    // mem_ack on the expiry cycle wins, so the flag only sets on a real timeout.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            timeout_q <= 1'b0;
        end else if ((state == ST_READ) && expire && !mem_ack) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    logic [31:0] timeout_cfg_unused;

    assign timeout_cfg_unused = TIMEOUT_CYCLES;
    assign expire             = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= ST_IDLE;
            dest_q <= DEST_ZERO;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_next;
            dest_q <= dest_next;
            addr_q <= addr_next;
            data_q <= data_next;
        end
    end

    always_comb begin
        state_next = state;
        dest_next  = dest_q;
        addr_next  = addr_q;
        data_next  = data_q;
        dest_ack   = (dest_q == DEST_ONE) ? one_ack : zero_ack;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_next  = req_addr;
                    dest_next  = req_dest;
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    data_next  = mem_rdata;
                    state_next = ST_DELIVER;
                end else if (expire) begin
                    data_next  = DATA_W'(TIMEOUT_DATA);
                    state_next = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (dest_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign mem_rd_en  = (state == ST_READ);
    assign mem_addr   = addr_q;
    assign zero_valid = channel_valid(state, dest_q, DEST_ZERO);
    assign one_valid  = channel_valid(state, dest_q, DEST_ONE);
    assign zero_data  = data_q;
    assign one_data   = data_q;

endmodule
